fp_reciprocal_arbiter: RTL and testbench
========================================

# fp_reciprocal_arbiter

Shares one `fp_reciprocal_estimate` datapath among `NUM_REQ` requesters (one per strand) through a two-stage pipeline. A round-robin arbiter grants one request per cycle. The operand is registered, the estimate is computed combinationally, and the result is registered with the winning requester's ID. The block sits between strand-level reciprocal instruction issue and the writeback path, and supports full backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters; must be 2..16.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous; discards all in-flight operations.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_value_i`  in  32*NUM_REQ  operands; requester i occupies bits [32i+31:32i], IEEE single precision.
- `req_ready_o`  out  NUM_REQ  one-hot accept; the request is transferred when `req_valid_i[i] && req_ready_o[i]`.
- `result_valid_o`  out  1  output register holds a result.
- `result_id_o`  out  ID_WIDTH  requester that issued the result.
- `result_value_o`  out  32  reciprocal estimate (6-bit significand).
- `result_ready_i`  in  1  consumer accepts the result.
- `busy_o`  out  1  either pipeline stage is occupied.

## Operation
- State:
  - s1 holds {valid, id, operand}.
  - s2 holds {valid, id, result}.
  - `rr_ptr` (ID_WIDTH bits) is the round-robin priority pointer.
- Reset values: s1.valid=0, s2.valid=0, `rr_ptr`=0. All data registers are 0, so `result_id_o`=0 and `result_value_o`=0. `req_ready_o`=0, `busy_o`=0.
- `advance2` = !s2.valid || `result_ready_i`.
- `advance1` = !s1.valid || `advance2`.
- Arbitration happens only when `advance1` && !`flush_i`. The winner is the first set bit of `req_valid_i`, searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
- `req_ready_o` is one-hot to the winner, and all zero when there is no request, no `advance1`, or `flush_i`=1. `req_ready_o` may depend combinationally on `req_valid_i` and `result_ready_i`.
- On a grant to i: `rr_ptr` <= (i+1) mod NUM_REQ. Otherwise `rr_ptr` holds.
- s1 load when `advance1`: valid <= grant, with the granted id and operand.
- s2 load when `advance2`: valid <= s1.valid, id <= s1.id, result <= estimate(s1.operand).
- The estimate is the `fp_reciprocal_estimate` function:
  - exponent = 253 − e + (top 6 significand bits == 0), 8-bit wraparound;
  - significand = 6-bit LUT value followed by 17 zeros;
  - e==0 gives signed infinity;
  - infinity gives signed zero;
  - NaN gives 0x7FC00000.
- `result_value_o`/`result_id_o` are undefined-but-stable while `result_valid_o`=0. While `result_valid_o`=1 and `result_ready_i`=0 they must hold constant.
- `flush_i`=1 at an edge clears s1.valid and s2.valid and suppresses grants in that cycle. `rr_ptr` is unchanged. `flush_i` takes priority over every load.
- Requesters must hold valid and value until ready. The block never accepts two requests in one cycle.
- `busy_o` = s1.valid || s2.valid.

## Timing
- Latency: a request accepted at edge N is presented on `result_*` after edge N+1. It is visible during cycle N+1→N+2 when there is no stall.
- Throughput: one result per cycle with `result_ready_i` held at 1.
- Stall: when s2 is full and `result_ready_i`=0, s2 holds. s1 holds if full; if s1 is empty, exactly one more request may be accepted into it. No result is lost or duplicated.
- Simultaneous `result_ready_i`=1 and s2.valid=1 with s1.valid=1: s2 reloads from s1 in the same edge, so there is no bubble.
- Asynchronous reset mid-operation: all stages are cleared immediately and `rr_ptr` returns to 0. Pending requests must re-present.
- Fairness: a continuously asserting requester is granted within NUM_REQ grants.

## Test plan
- NUM_REQ=4. Single request from requester 2 with operand 0x40000000, `result_ready_i`=1. Required: `req_ready_o`=4'b0100 for one cycle, then `result_valid_o`=1 one cycle later with id=2 and value 0x3F000000.
- All four requesters valid, operands 1.0/2.0/4.0/−1.0 (0x3F800000/0x40000000/0x40800000/0xBF800000). Required: grants in order 0,1,2,3,0,…; results 0x3F800000, 0x3F000000, 0x3E800000, 0xBF800000 on four consecutive cycles.
- Special operands 0x00000000, 0x7F800000, 0x7FC00001. Required results in order: 0x7F800000, 0x00000000, 0x7FC00000.
- Backpressure: hold `result_ready_i`=0 for 5 cycles with requesters 0 and 1 streaming. Required: exactly two accepts, then `req_ready_o`=0 and `result_*` stable. On release, both results emerge in order with no drop or duplicate.
- `flush_i` with both stages full. Required: `result_valid_o`=0 and `busy_o`=0 next cycle, `rr_ptr` unchanged, the next grant follows the prior order.
- Assert `reset` asynchronously mid-stream. Required: all outputs go to their reset values without waiting for a clock edge, and the first grant after release goes to the lowest-index valid requester.

Source files
------------

// File: rtl/fp_reciprocal_arbiter.sv
// Round-robin arbiter sharing one reciprocal-estimate datapath among NUM_REQ requesters.
// Two-stage pipeline (operand register, result register) with full backpressure and flush.
module fp_reciprocal_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [32*NUM_REQ-1:0] req_value_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic                  result_valid_o,
    output logic [ID_WIDTH-1:0]   result_id_o,
    output logic [31:0]           result_value_o,
    input  logic                  result_ready_i,
    output logic                  busy_o
);

    // Entry i is the fraction of 2/(1 + i/64) - 1 truncated to 6 bits; entry 0 wraps to 0
    // and the exponent picks up the carry instead.
    function automatic logic [383:0] build_lut();
        logic [383:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            t[i*6 +: 6] = 6'((8192 / (64 + i)) - 64);
        end
        return t;
    endfunction

    localparam logic [383:0] RECIP_LUT = build_lut();

    function automatic logic [31:0] recip_estimate(input logic [31:0] x);
        logic [7:0] e;
        logic [5:0] idx;
        logic [7:0] exp_out;
        e   = x[30:23];
        idx = x[22:17];
        exp_out = 8'd253 - e + {7'd0, idx == 6'd0};
        if (e == 8'hff) begin
            return (x[22:0] != 23'd0) ? 32'h7fc0_0000 : {x[31], 31'd0};
        end
        if (e == 8'h00) begin
            return {x[31], 8'hff, 23'd0};
        end
        return {x[31], exp_out, RECIP_LUT[int'(idx)*6 +: 6], 17'd0};
    endfunction

    logic                s1_valid;
    logic [ID_WIDTH-1:0] s1_id;
    logic [31:0]         s1_operand;
    logic                s2_valid;
    logic [ID_WIDTH-1:0] s2_id;
    logic [31:0]         s2_result;
    logic [ID_WIDTH-1:0] rr_ptr;

    logic                advance1;
    logic                advance2;
    logic                grant_found;
    logic                grant_en;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] rr_next;
    logic [31:0]         grant_value;
    logic [31:0]         req_ops [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign req_ops[g] = req_value_i[g*32 +: 32];
    end

    assign advance2 = !s2_valid || result_ready_i;
    assign advance1 = !s1_valid || advance2;

    // Search upward from rr_ptr, wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_value = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
                grant_value = req_ops[cand];
            end
        end
    end

    assign grant_en = advance1 && !flush_i && grant_found && !reset;
    assign rr_next  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : ID_WIDTH'(grant_id + 1'b1);

    always_comb begin
        req_ready_o = '0;
        if (grant_en) begin
            req_ready_o = NUM_REQ'(1) << grant_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_operand <= '0;
            s2_valid   <= 1'b0;
            s2_id      <= '0;
            s2_result  <= '0;
            rr_ptr     <= '0;
        end else begin
            if (grant_en) begin
                rr_ptr <= rr_next;
            end
            if (flush_i) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (advance1) begin
                    s1_valid <= grant_en;
                    if (grant_en) begin
                        s1_id      <= grant_id;
                        s1_operand <= grant_value;
                    end
                end
                if (advance2) begin
                    s2_valid  <= s1_valid;
                    s2_id     <= s1_id;
                    s2_result <= recip_estimate(s1_operand);
                end
            end
        end
    end

    assign result_valid_o = s2_valid;
    assign result_id_o    = s2_id;
    assign result_value_o = s2_result;
    assign busy_o         = s1_valid || s2_valid;

endmodule

// File: tb/tb_fp_reciprocal_arbiter.sv
// Scoreboard bench for fp_reciprocal_arbiter: accepts push expected {id, estimate},
// result handshakes pop and compare; directed phases check arbitration, stall, flush, reset.
module tb_fp_reciprocal_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush_i = 1'b0;
    logic [NR-1:0] req_valid_i = '0;
    logic [127:0]  req_value_i = '0;
    logic [NR-1:0] req_ready_o;
    logic          result_valid_o;
    logic [1:0]    result_id_o;
    logic [31:0]   result_value_o;
    logic          result_ready_i = 1'b1;
    logic          busy_o;

    fp_reciprocal_arbiter #(.NUM_REQ(NR)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_value_i    (req_value_i),
        .req_ready_o    (req_ready_o),
        .result_valid_o (result_valid_o),
        .result_id_o    (result_id_o),
        .result_value_o (result_value_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] res_log[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_results = 0;
    logic [NR-1:0] last_accept = '0;
    exp_t        mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Independent reference: 6-bit truncation of 2/(1+m) - 1 via real arithmetic.
    function automatic logic [31:0] model(input logic [31:0] x);
        int   e;
        int   idx;
        int   lut;
        real  m;
        logic [7:0] ex;
        e   = int'(x[30:23]);
        idx = int'(x[22:17]);
        if (e == 255) return (x[22:0] != 0) ? 32'h7fc0_0000 : {x[31], 31'd0};
        if (e == 0) return {x[31], 8'hff, 23'd0};
        m   = 2.0 / (1.0 + real'(idx) / 64.0);
        lut = int'($floor((m - 1.0) * 64.0)) & 63;
        ex  = 8'(253 - e + ((idx == 0) ? 1 : 0));
        return {x[31], ex, 6'(lut), 17'd0};
    endfunction

    always @(negedge clk) begin
        last_accept = '0;
        if (reset) begin
            sb.delete();
        end else begin
            if (result_valid_o && result_ready_i) begin
                n_results++;
                res_log.push_back(result_value_o);
                if (sb.size() == 0) begin
                    check_eq("spurious_result", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("res_id", 32'(result_id_o), 32'(mon_e.id));
                    check_eq("res_val", result_value_o, mon_e.val);
                end
            end
            if (req_ready_o != '0) begin
                check_eq("ready_onehot", 32'($onehot(req_ready_o)), 32'd1);
                for (int i = 0; i < NR; i++) begin
                    if (req_ready_o[i]) begin
                        check_eq("ready_to_valid", 32'(req_valid_i[i]), 32'd1);
                        if (req_valid_i[i]) begin
                            sb.push_back({2'(i), model(req_value_i[i*32 +: 32])});
                            grant_log.push_back(i);
                            last_accept[i] = 1'b1;
                        end
                    end
                end
            end
            if (flush_i) sb.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_value_i[i*32 +: 32] = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid_i = '0;
        flush_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        req_valid_i = '0;
        flush_i = 1'b0;
        result_ready_i = 1'b1;
        for (int c = 0; c < 20 && (busy_o || sb.size() != 0); c++) tick();
        check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("drain_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic send(input int i, input logic [31:0] v);
        logic ok;
        ok = 1'b0;
        set_op(i, v);
        req_valid_i[i] = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            if (last_accept[i]) ok = 1'b1;
        end
        req_valid_i[i] = 1'b0;
        check_eq("send_accept", 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hff80_0000;
            2: return 32'h7fc0_0001;
            3: return 32'h0012_3456;
            default: return $urandom();
        endcase
    endfunction

    int          g0;
    int          r0;
    logic [31:0] held_val;
    logic [1:0]  held_id;
    logic [31:0] spec_ops [8];

    initial begin
        // Reset state, with requests pending to show ready is gated.
        req_valid_i = 4'hf;
        #3;
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_valid", 32'(result_valid_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_id", 32'(result_id_o), 32'd0);
        check_eq("rst_value", result_value_o, 32'd0);
        req_valid_i = '0;
        tick();
        reset = 1'b0;

        // Single request from requester 2.
        tick();
        set_op(2, 32'h4000_0000);
        req_valid_i = 4'b0100;
        #1;
        check_eq("t1_ready", 32'(req_ready_o), 32'b0100);
        tick();
        req_valid_i = '0;
        check_eq("t1_s1_only_valid", 32'(result_valid_o), 32'd0);
        check_eq("t1_s1_only_busy", 32'(busy_o), 32'd1);
        tick();
        check_eq("t1_out_valid", 32'(result_valid_o), 32'd1);
        check_eq("t1_out_id", 32'(result_id_o), 32'd2);
        check_eq("t1_out_value", result_value_o, 32'h3f00_0000);
        tick();
        check_eq("t1_out_gone", 32'(result_valid_o), 32'd0);

        // All four requesters streaming.
        do_reset();
        grant_log.delete();
        res_log.delete();
        r0 = n_results;
        set_op(0, 32'h3f80_0000);
        set_op(1, 32'h4000_0000);
        set_op(2, 32'h4080_0000);
        set_op(3, 32'hbf80_0000);
        req_valid_i = 4'hf;
        result_ready_i = 1'b1;
        repeat (8) tick();
        check_eq("t2_grants_in_8", 32'(grant_log.size()), 32'd8);
        drain();
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) check_eq("t2_grant_order", 32'(grant_log[k]), 32'(k % 4));
        end
        check_eq("t2_results", 32'(n_results - r0), 32'd8);
        if (res_log.size() >= 4) begin
            check_eq("t2_r0", res_log[0], 32'h3f80_0000);
            check_eq("t2_r1", res_log[1], 32'h3f00_0000);
            check_eq("t2_r2", res_log[2], 32'h3e80_0000);
            check_eq("t2_r3", res_log[3], 32'hbf80_0000);
        end else begin
            check_eq("t2_res_count", 32'(res_log.size()), 32'd4);
        end

        // Special operands and a few LUT points.
        res_log.delete();
        spec_ops = '{32'h0000_0000, 32'h7f80_0000, 32'h7fc0_0001, 32'h3fc0_0000,
                     32'h8000_0000, 32'h7f7f_ffff, 32'hff80_0000, 32'h0040_0000};
        for (int k = 0; k < 8; k++) send(1, spec_ops[k]);
        drain();
        if (res_log.size() >= 4) begin
            check_eq("t3_zero", res_log[0], 32'h7f80_0000);
            check_eq("t3_inf", res_log[1], 32'h0000_0000);
            check_eq("t3_nan", res_log[2], 32'h7fc0_0000);
            check_eq("t3_1p5", res_log[3], 32'h3f2a_0000);
        end else begin
            check_eq("t3_res_count", 32'(res_log.size()), 32'd8);
        end

        // Backpressure with requesters 0 and 1 streaming.
        result_ready_i = 1'b0;
        set_op(0, 32'h4040_0000);
        set_op(1, 32'h3e00_0000);
        req_valid_i = 4'b0011;
        g0 = grant_log.size();
        r0 = n_results;
        held_val = '0;
        held_id = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) begin
                held_val = result_value_o;
                held_id = result_id_o;
            end
            if (k >= 2) begin
                check_eq("t4_hold_valid", 32'(result_valid_o), 32'd1);
                check_eq("t4_hold_value", result_value_o, held_val);
                check_eq("t4_hold_id", 32'(result_id_o), 32'(held_id));
            end
        end
        check_eq("t4_accepts", 32'(grant_log.size() - g0), 32'd2);
        check_eq("t4_ready_low", 32'(req_ready_o), 32'd0);
        drain();
        check_eq("t4_released", 32'(n_results - r0), 32'd2);

        // Flush with both stages full.
        do_reset();
        set_op(0, 32'h3f80_0000);
        set_op(1, 32'h4000_0000);
        set_op(2, 32'h4080_0000);
        set_op(3, 32'hbf80_0000);
        req_valid_i = 4'hf;
        result_ready_i = 1'b0;
        tick();
        tick();
        check_eq("t5_full_busy", 32'(busy_o), 32'd1);
        check_eq("t5_full_valid", 32'(result_valid_o), 32'd1);
        flush_i = 1'b1;
        tick();
        check_eq("t5_flush_valid", 32'(result_valid_o), 32'd0);
        check_eq("t5_flush_busy", 32'(busy_o), 32'd0);
        result_ready_i = 1'b1;
        #1;
        check_eq("t5_flush_no_grant", 32'(req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        check_eq("t5_still_empty", 32'(busy_o), 32'd0);
        #1;
        check_eq("t5_next_grant", 32'(req_ready_o), 32'b0100);
        tick();
        drain();

        // Asynchronous reset mid-stream.
        req_valid_i = 4'hf;
        result_ready_i = 1'b1;
        repeat (3) tick();
        check_eq("t6_pre_valid", 32'(result_valid_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(result_valid_o), 32'd0);
        check_eq("t6_rst_busy", 32'(busy_o), 32'd0);
        check_eq("t6_rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("t6_rst_id", 32'(result_id_o), 32'd0);
        check_eq("t6_rst_value", result_value_o, 32'd0);
        tick();
        req_valid_i = 4'b0110;
        reset = 1'b0;
        #1;
        check_eq("t6_first_grant", 32'(req_ready_o), 32'b0010);
        tick();
        drain();

        // Random mix with random consumer stalls.
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (last_accept[i] || !req_valid_i[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid_i[i] = 1'b1;
                        set_op(i, rand_op());
                    end else begin
                        req_valid_i[i] = 1'b0;
                    end
                end
            end
            result_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
